coin_sense: RTL
===============

# coin_sense

Front-end stage of the vending controller: conditions the two raw coin-sensor lines and produces the clean single-cycle coin pulses `i` (coin type A) and `j` (coin type B) that the `vend` FSM consumes. Each sensor line is synchronised and debounced, and each valid insertion is recorded once. Recorded coins are queued in a small FIFO and presented to `vend` one per cycle, unless `vend` is holding off. The block also reports jams (both sensors at once) and overflow (coin lost because the queue is full).

## Interface
Parameters:
- `DEB_CYCLES`, 4: consecutive stable synchronised samples needed to accept a level change (range 1..255).
- `QDEPTH`, 4: coin queue depth (power of two, at least 2).

Ports:
- `clk`  in  1  Single clock. All logic is rising-edge.
- `rst`  in  1  Synchronous, active-high reset.
- `coin_a_raw`  in  1  Asynchronous sensor, type-A coin present.
- `coin_b_raw`  in  1  Asynchronous sensor, type-B coin present.
- `hold`  in  1  `vend` busy; while high, no pulse is emitted.
- `i`  out  1  One-cycle pulse, one type-A coin delivered.
- `j`  out  1  One-cycle pulse, one type-B coin delivered.
- `full`  out  1  Queue holds QDEPTH entries.
- `jam`  out  1  One-cycle pulse, simultaneous A/B commit; both coins discarded.
- `ovf`  out  1  One-cycle pulse, coin committed while queue full; coin discarded.

## Operation
- **Synchroniser.** Each raw line passes through a 2-flop synchroniser.
- **Debounce FSM.** Each channel runs its own FSM with states IDLE, DEB_HI, PRESENT, DEB_LO and an 8-bit stable counter.
  - IDLE→DEB_HI when the synced line is 1. DEB_HI→IDLE if the line returns to 0 before the count completes.
  - DEB_HI→PRESENT when the count reaches DEB_CYCLES. This transition is the channel's **commit**.
  - PRESENT→DEB_LO when the line is 0. DEB_LO→PRESENT if the line returns to 1.
  - DEB_LO→IDLE after DEB_CYCLES consecutive 0 samples.
  - A coin held high indefinitely commits exactly once.
- **Commit resolution, same cycle:**
  - Both channels commit: `jam` pulses, nothing is pushed, and both channels still enter PRESENT.
  - One channel commits and the queue is not full, or is full but popping this cycle: push 1 entry, 0 = A, 1 = B.
  - One channel commits and the queue is full and not popping: `ovf` pulses and the coin is dropped.
- **Pop.** When the queue is non-empty and `hold`=0, the head is popped and `i` or `j` is registered high for exactly one cycle. `i` and `j` are never high together. Successive entries go out on consecutive cycles.
- **Queue.** Circular buffer with read/write pointers and an occupancy count. Pointers wrap modulo QDEPTH. Push and pop in the same cycle leave the count unchanged.
- **Reset.** All FSMs go to IDLE, counters and pointers to 0, and the queue is emptied. `i`, `j`, `full`, `jam`, `ovf` all read 0 in the cycle after the reset edge. Reset asserted mid-debounce or with coins queued discards everything.

## Timing
- Throughput is 1 coin per cycle out of the queue.
- Raw high stable from before edge 0, queue empty, `hold`=0: commit/push at edge DEB_CYCLES+2, and `i`/`j` high for the single cycle after edge DEB_CYCLES+3.
- With the default DEB_CYCLES=4, the pulse follows edge 7.
- `full` is registered and reflects the occupancy after each edge.
- `jam` and `ovf` are registered in the same edge as the commit.
- `hold` is sampled at the pop edge. Asserting `hold` suppresses the next edge's pulse, with no combinational path from `hold` to `i`/`j`.

## Configuration
- `COIN_SENSE_CNT_EN`
  - Defined: adds outputs `cnt_a`, `cnt_b` (16 bits each). Each counts coins delivered on `i`/`j`, saturates at 16'hFFFF, and is cleared by `rst`.
  - Undefined: these ports and counters do not exist, and the behaviour of all other ports is identical.

## Structure
- Shared package `coin_pkg`:
  - Debounce state typedef (IDLE, DEB_HI, PRESENT, DEB_LO).
  - Coin-type constants `COIN_A`=0, `COIN_B`=1.
  - Counter width constant 16.
- Sub-module `coin_debounce`: synchroniser, debounce FSM and counter, with a `commit` output. It is instantiated twice. Commit resolution, queue, and pulse generation live in `coin_sense`.

## Test plan
- A-line high for 20 cycles, B low, DEB_CYCLES=4 → exactly one `i` pulse, after edge 7; `j` stays 0.
- A-line glitch high for 3 cycles → no commit, no `i`; FSM back in IDLE.
- Both lines rise on the same edge → exactly one `jam` pulse; no `i`/`j`; queue count stays 0.
- `hold`=1, five B coins committed with QDEPTH=4 → `full`=1 after the 4th push and `ovf` pulses on the 5th. Drop `hold` → exactly 4 consecutive `j` pulses, then `full`=0.
- Queue full and `hold` released on the same edge as a new A commit → no `ovf`; all 5 coins delivered in order.
- `rst` pulsed while 2 coins are queued and A is in DEB_HI → no `i`/`j` afterwards until a fresh insertion; `cnt_a`/`cnt_b` read 0 (when `COIN_SENSE_CNT_EN` is defined).

Source files
------------

// File: rtl/coin_pkg.sv
// coin_pkg: shared debounce state encoding, coin-type codes and counter width.
package coin_pkg;
    typedef logic [1:0] deb_state_t;
    localparam deb_state_t IDLE    = 2'd0;
    localparam deb_state_t DEB_HI  = 2'd1;
    localparam deb_state_t PRESENT = 2'd2;
    localparam deb_state_t DEB_LO  = 2'd3;
    localparam logic COIN_A = 1'b0;
    localparam logic COIN_B = 1'b1;
    localparam int CNT_W = 16;
endpackage

// File: rtl/coin_debounce.sv
// coin_debounce: 2-flop synchroniser plus debounce FSM; commit marks the accepted rising level.
module coin_debounce
    import coin_pkg::*;
#(
    parameter int DEB_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic commit
);
    logic [1:0] sync;
    deb_state_t state;
    logic [7:0] cnt;
    logic line;
    logic done;
    assign line = sync[1];
    // cnt starts at 0 on the first stable sample, so DEB_CYCLES samples end at DEB_CYCLES-1
    assign done = cnt == 8'(DEB_CYCLES - 1);
    assign commit = state == DEB_HI && line && done;
    always_ff @(posedge clk) begin
        if (rst) begin
            sync  <= 2'b00;
            state <= IDLE;
            cnt   <= 8'd0;
        end else begin
            sync <= {sync[0], raw};
            case (state)
                IDLE: begin
                    cnt <= 8'd0;
                    if (line) state <= DEB_HI;
                end
                DEB_HI: begin
                    if (!line) state <= IDLE;
                    else if (done) state <= PRESENT;
                    else cnt <= cnt + 8'd1;
                end
                PRESENT: begin
                    cnt <= 8'd0;
                    if (!line) state <= DEB_LO;
                end
                default: begin
                    if (line) state <= PRESENT;
                    else if (done) state <= IDLE;
                    else cnt <= cnt + 8'd1;
                end
            endcase
        end
    end
endmodule

// File: rtl/coin_sense.sv
// coin_sense: debounced coin front-end with jam/overflow detection and a pulse queue to vend.
// Optional delivered-coin counters cnt_a/cnt_b are enabled by COIN_SENSE_CNT_EN.
module coin_sense
    import coin_pkg::*;
#(
    parameter int DEB_CYCLES = 4,
    parameter int QDEPTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic coin_a_raw,
    input  logic coin_b_raw,
    input  logic hold,
    output logic i,
    output logic j,
    output logic full,
    output logic jam,
    output logic ovf
`ifdef COIN_SENSE_CNT_EN
    ,
    output logic [CNT_W-1:0] cnt_a,
    output logic [CNT_W-1:0] cnt_b
`endif
);
    localparam int AW = $clog2(QDEPTH);
    logic commit_a, commit_b, one, push, pop;
    logic [QDEPTH-1:0] q;
    logic [AW-1:0] rd, wr;
    logic [AW:0] count;

    coin_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_a (.clk(clk), .rst(rst), .raw(coin_a_raw), .commit(commit_a));
    coin_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_b (.clk(clk), .rst(rst), .raw(coin_b_raw), .commit(commit_b));

    assign full = count == (AW+1)'(QDEPTH);
    assign pop  = count != '0 && !hold;
    assign one  = commit_a ^ commit_b;
    // a full queue still accepts a coin when its head leaves in the same cycle
    assign push = one && (!full || pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            q     <= '0;
            rd    <= '0;
            wr    <= '0;
            count <= '0;
            i     <= 1'b0;
            j     <= 1'b0;
            jam   <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            if (push) begin
                q[wr] <= commit_b ? COIN_B : COIN_A;
                wr    <= wr + AW'(1);
            end
            if (pop) rd <= rd + AW'(1);
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
            i     <= pop && q[rd] == COIN_A;
            j     <= pop && q[rd] == COIN_B;
            jam   <= commit_a && commit_b;
            ovf   <= one && !push;
        end
    end

`ifdef COIN_SENSE_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_a <= '0;
            cnt_b <= '0;
        end else begin
            if (i && cnt_a != '1) cnt_a <= cnt_a + CNT_W'(1);
            if (j && cnt_b != '1) cnt_b <= cnt_b + CNT_W'(1);
        end
    end
`endif
endmodule
